// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC address layout and flit sizing for the spine ports.
`ifndef NOC_FLIT_W
`define NOC_FLIT_W(dw) (noc_pkg::ADDR_W + (dw))
`endif
package noc_pkg;
    localparam int ADDR_W   = 6;
    localparam int GROUP_W  = 4;
    localparam int LEAF_W   = 2;
    localparam int GROUP_HI = 5;
    localparam int GROUP_LO = 2;
    localparam int LEAF_HI  = 1;
    localparam int LEAF_LO  = 0;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [GROUP_W-1:0] group,
                                                    input logic [LEAF_W-1:0] leaf);
        return {group, leaf};
    endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty.
module noc_sync_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/spine_leaf_tx.sv
// spine_leaf_tx: spine egress port; filters flits for one leaf, buffers them and paces them onto the leaf link.
module spine_leaf_tx import noc_pkg::*; #(
    parameter int DWIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter logic [GROUP_W-1:0] GROUP_ID = 4'b0001,
    parameter logic [LEAF_W-1:0] LEAF_ID = 2'd3,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_enable,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_dest_addr,
    output logic              in_ready,
    output logic [DWIDTH-1:0] leaf_out_data,
    output logic              leaf_out_valid,
    output logic [ADDR_W-1:0] leaf_out_dest_addr,
    output logic              misroute_drop,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [CW-1:0]     fifo_count,
    output logic [15:0]       sent_count,
    output logic [7:0]        drop_count
);
    localparam int FW = `NOC_FLIT_W(DWIDTH);

    logic [FW-1:0] head;
    logic accept, match, pop;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign match    = in_dest_addr[GROUP_HI:GROUP_LO] == GROUP_ID &&
                      in_dest_addr[LEAF_HI:LEAF_LO] == LEAF_ID;
    assign pop      = tx_enable && !fifo_empty;

    noc_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && match),
        .pop   (pop),
        .wdata ({in_dest_addr, in_data}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leaf_out_valid     <= 1'b0;
            leaf_out_data      <= '0;
            leaf_out_dest_addr <= '0;
            misroute_drop      <= 1'b0;
            sent_count         <= '0;
            drop_count         <= '0;
        end else begin
            leaf_out_valid <= pop;
            misroute_drop  <= accept && !match;
            if (pop) begin
                {leaf_out_dest_addr, leaf_out_data} <= head;
                sent_count <= (sent_count != 16'hFFFF) ? sent_count + 16'd1 : sent_count;
            end
            if (accept && !match)
                drop_count <= (drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
        end
    end
endmodule

// File: tb/tb_spine_leaf_tx.sv
// tb_spine_leaf_tx: directed and randomized stimulus checked against a queue-based model of the egress port.
`timescale 1ns/1ps
module tb_spine_leaf_tx;
    localparam logic [5:0] MATCH = 6'b000111;

    logic clk = 0, reset = 0, tx_enable = 0, in_valid = 0;
    logic [15:0] in_data = 0;
    logic [5:0] in_dest_addr = 0;
    logic in_ready, leaf_out_valid, misroute_drop, fifo_full, fifo_empty;
    logic [15:0] leaf_out_data, sent_count;
    logic [5:0] leaf_out_dest_addr;
    logic [3:0] fifo_count;
    logic [7:0] drop_count;

    int checks = 0, errors = 0;

    logic [21:0] q[$];
    logic [21:0] last;
    logic exp_valid, exp_drop;
    int sent, drop;

    spine_leaf_tx dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .in_data(in_data),
        .in_valid(in_valid), .in_dest_addr(in_dest_addr), .in_ready(in_ready),
        .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
        .leaf_out_dest_addr(leaf_out_dest_addr), .misroute_drop(misroute_drop),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .sent_count(sent_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("leaf_out_valid", 32'(leaf_out_valid), 32'(exp_valid));
        chk("leaf_out_data", 32'(leaf_out_data), 32'(last[15:0]));
        chk("leaf_out_dest", 32'(leaf_out_dest_addr), 32'(last[21:16]));
        chk("misroute_drop", 32'(misroute_drop), 32'(exp_drop));
        chk("fifo_count", 32'(fifo_count), q.size());
        chk("fifo_full", 32'(fifo_full), 32'(q.size() == 8));
        chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 8));
        chk("sent_count", 32'(sent_count), sent);
        chk("drop_count", 32'(drop_count), drop);
    endtask

    task automatic model_reset();
        q.delete();
        last = 0; exp_valid = 0; exp_drop = 0; sent = 0; drop = 0;
    endtask

    // one clock: the model uses the pre-edge occupancy for both accept and drain decisions
    task automatic step(input logic v, input logic [5:0] d, input logic [15:0] data, input logic en);
        bit acc, pop;
        in_valid = v; in_dest_addr = d; in_data = data; tx_enable = en;
        acc = v && q.size() < 8;
        pop = en && q.size() > 0;
        exp_valid = pop;
        exp_drop = acc && d != MATCH;
        if (pop) begin
            last = q.pop_front();
            if (sent < 65535) sent++;
        end
        if (acc && d == MATCH) q.push_back({d, data});
        if (exp_drop && drop < 255) drop++;
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) step(0, 6'd0, 16'd0, en);
    endtask

    function automatic logic [5:0] rand_dest();
        return ($urandom_range(0, 1) == 1) ? MATCH : 6'($urandom_range(0, 63));
    endfunction

    initial begin
        model_reset();
        #12;
        check_all();
        @(posedge clk); #1;
        reset = 1;
        idle(2, 1);

        step(1, MATCH, 16'hA5A5, 1);
        idle(4, 1);

        step(1, 6'b001011, 16'h1234, 1);
        idle(3, 1);

        for (int i = 0; i < 9; i++) step(1, MATCH, 16'($urandom_range(0, 65535)), 0);
        idle(10, 1);

        for (int i = 0; i < 20; i++) step(1, MATCH, 16'($urandom_range(0, 65535)), 1);
        idle(2, 1);

        for (int i = 0; i < 5; i++) step(1, MATCH, 16'($urandom_range(0, 65535)), 0);
        reset = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        reset = 1;
        idle(6, 1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), rand_dest(), 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 3) != 0));
        idle(10, 1);

        for (int i = 0; i < 260; i++) step(1, 6'b100000, 16'($urandom_range(0, 65535)), 1);
        for (int i = 0; i < 65540; i++) step(1, MATCH, 16'($urandom_range(0, 65535)), 1);
        idle(3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spine_leaf_tx.md
# spine_leaf_tx

Spine-side egress port that drives one leaf router's spine input (data, valid, 6-bit destination address). It accepts flits from the spine crossbar over a valid/ready handshake and buffers them in a FIFO. It filters out flits not addressed to its leaf and paces them onto the leaf link one flit per cycle under an enable. One instance sits on each spine-to-leaf link; the leaf-side spine input has no backpressure, so all flow control ends here.

## Interface
- DWIDTH, 16, flit data width
- FIFO_DEPTH, 8, buffer entries (power of two, ≥2)
- GROUP_ID, 4'b0001, group field this link serves (dest_addr[5:2])
- LEAF_ID, 2'd3, leaf index this link serves (dest_addr[1:0])
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- tx_enable  in  1  permits draining to the leaf link
- in_data  in  DWIDTH  flit from spine crossbar
- in_valid  in  1  flit present
- in_dest_addr  in  6  destination {group[3:0], leaf[1:0]}
- in_ready  out  1  port can accept (= !fifo_full)
- leaf_out_data  out  DWIDTH  flit to leaf spine input
- leaf_out_valid  out  1  one-cycle flit strobe
- leaf_out_dest_addr  out  6  destination of the flit on the link
- misroute_drop  out  1  one-cycle pulse when an accepted flit was discarded
- fifo_full  out  1  count == FIFO_DEPTH
- fifo_empty  out  1  count == 0
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- sent_count  out  16  flits delivered, saturates at 16'hFFFF
- drop_count  out  8  flits discarded, saturates at 8'hFF

## Operation
- Accept when in_valid && in_ready at a rising edge.
- Routing check on accept:
  - in_dest_addr == {GROUP_ID, LEAF_ID}: push {in_dest_addr, in_data} into the FIFO.
  - Otherwise: discard the flit without pushing. misroute_drop is 1 for the next cycle and drop_count increments.
- in_ready is purely !fifo_full.
  - No push while full, even if a pop happens in the same cycle.
- Drain: at each edge with tx_enable=1 and FIFO not empty, pop the head into the output register and set leaf_out_valid=1 for exactly one cycle. sent_count increments at the same edge.
- No pop otherwise; leaf_out_valid returns to 0.
  - leaf_out_data and leaf_out_dest_addr hold the last sent values.
- Back-to-back flits: with tx_enable held at 1 and the FIFO non-empty, one flit per cycle and leaf_out_valid stays continuously high.
- A push and a pop in the same edge leave the count unchanged. FIFO order is strict.
- Deasserting tx_enable freezes the FIFO contents. Accepting continues until full.
- Counters saturate and never wrap.
- All outputs are registered except in_ready, fifo_full and fifo_empty, which are derived from the count register.

## Timing
- Reset (reset=0, asynchronous) drives these values:
  - leaf_out_valid=0, leaf_out_data=0, leaf_out_dest_addr=0
  - misroute_drop=0, fifo_count=0, fifo_empty=1, fifo_full=0, in_ready=1
  - sent_count=0, drop_count=0
- Reset asserted mid-stream discards all buffered flits. Release is synchronous to the next clk edge.
- Latency with an empty FIFO and tx_enable=1: flit accepted at edge N is pushed at N and appears on leaf_out_* after edge N+1 (2-cycle in→out).
- misroute_drop asserts in the cycle after the accept edge.
- A full FIFO deasserts in_ready in the cycle after the filling edge and reasserts in the cycle after the first pop.

## Structure
- Shared package noc_pkg holds:
  - ADDR_W=6, GROUP_W=4, LEAF_W=2
  - address field slice positions (group [5:2], leaf [1:0])
  - flit struct/width macro {dest_addr, data}
- Sub-module noc_sync_fifo:
  - parameterised width/depth, synchronous push/pop, async active-low reset
  - count/full/empty outputs
  - intended for reuse by the other spine ports
- Top contains only the filter, output register and counters.

## Test plan
- Single flit, dest 6'b000111, data 16'hA5A5, tx_enable=1 → leaf_out_valid high 1 cycle, 2 cycles after accept, data A5A5, dest 000111; sent_count=1.
- Misrouted flit, dest 6'b001011 → no leaf_out_valid; misroute_drop pulses once; drop_count=1; fifo_count stays 0.
- tx_enable=0, push 9 valid flits → 8 accepted; in_ready=0 after the 8th; fifo_full=1. Raise tx_enable → 8 consecutive valid cycles in order; in_ready returns the cycle after the first pop.
- Continuous stream with tx_enable=1 → one flit per cycle; fifo_count stays ≤1; no gaps in leaf_out_valid.
- Reset pulsed low with 5 flits buffered → all outputs at reset values immediately. After release, no stale flit emerges.
- Force sent_count to 16'hFFFE and send 3 flits → count holds at 16'hFFFF.
